// File: rtl/keycode_event_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package  : kev_pkg
// Brief    : Event types, FSM states and the queued event record.
// Revision : 1.0 - initial release
// ============================================================================
package kev_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HELD = 2'b01,
    PEND = 2'b10
  } state_t;

  typedef struct packed {
    evt_type_t  evt_type;
    logic [7:0] code;
  } evt_t;

endpackage
`default_nettype wire

// File: rtl/keycode_event_queue_if.sv
`default_nettype none
// ============================================================================
// Interface : keycode_event_queue_if
// Brief     : Valid/ready event stream from the queue to its consumer.
// Revision  : 1.0 - initial release
// ============================================================================
interface keycode_event_queue_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic [1:0] evt_type;

  modport master (output evt_valid, output evt_code, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_type, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/keycode_event_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keycode_fifo
// Brief    : Show-ahead event FIFO with sticky overflow on a dropped push.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_push_data,
  input  wire logic                     i_pop,
  input  wire logic                     i_overflow_clr,
  output logic      [WIDTH-1:0]         o_head_data,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count,
  output logic                          o_overflow
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             r_overflow;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // Extra pointer MSB keeps full (DEPTH) and empty (0) distinguishable.
  assign o_count     = r_wr_ptr - r_rd_ptr;
  assign o_empty     = (o_count == '0);
  assign w_full      = (o_count == c_FULL);
  assign w_pop       = i_pop && !o_empty;
  assign w_push      = i_push && (!w_full || w_pop);
  assign o_head_data = r_mem[r_rd_ptr[c_AW-1:0]];
  assign o_overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (i_overflow_clr)        r_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keycode_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : keycode_event_queue
// Brief    : Turns keycode level changes into PRESS/RELEASE/REPEAT events.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_event_queue
  import kev_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DELAY_CYC = 25000000,
  parameter int RATE_CYC  = 2500000
) (
  input  wire logic                   clk_clk,
  input  wire logic                   reset_reset_n,
  input  wire logic [7:0]             keycode_in,
  input  wire logic                   overflow_clr,
  keycode_event_queue_if.master       evt,
  output logic      [$clog2(DEPTH):0] count,
  output logic      [7:0]             held_code,
  output logic                        overflow
);

  localparam int               c_TMAX       = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int               c_TW         = $clog2(c_TMAX);
  localparam logic [c_TW-1:0]  c_DELAY_LAST = c_TW'(DELAY_CYC - 1);
  localparam logic [c_TW-1:0]  c_RATE_LAST  = c_TW'(RATE_CYC - 1);

  state_t            r_state;
  logic [7:0]        r_held;
  logic [c_TW-1:0]   r_timer;
  logic              r_rep;
  logic              r_push;
  evt_t              r_push_evt;
  evt_t              w_head;
  logic              w_empty;

  // Push request is registered, so a change seen at edge N lands in the FIFO at N+1.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= IDLE;
      r_held     <= KEY_NONE;
      r_timer    <= '0;
      r_rep      <= 1'b0;
      r_push     <= 1'b0;
      r_push_evt <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        IDLE, PEND: begin
          if (keycode_in != KEY_NONE) begin
            r_push     <= 1'b1;
            r_push_evt <= '{evt_type: EVT_PRESS, code: keycode_in};
            r_held     <= keycode_in;
            r_timer    <= '0;
            r_rep      <= 1'b0;
            r_state    <= HELD;
          end else begin
            r_state    <= IDLE;
          end
        end
        HELD: begin
          if (keycode_in == r_held) begin
            if (r_timer == (r_rep ? c_RATE_LAST : c_DELAY_LAST)) begin
              r_push     <= 1'b1;
              r_push_evt <= '{evt_type: EVT_REPEAT, code: r_held};
              r_timer    <= '0;
              r_rep      <= 1'b1;
            end else begin
              r_timer    <= r_timer + c_TW'(1);
            end
          end else begin
            r_push     <= 1'b1;
            r_push_evt <= '{evt_type: EVT_RELEASE, code: r_held};
            r_held     <= KEY_NONE;
            r_state    <= (keycode_in == KEY_NONE) ? IDLE : PEND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  keycode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(evt_t))
  ) u_fifo (
    .clk            (clk_clk),
    .rst_n          (reset_reset_n),
    .i_push         (r_push),
    .i_push_data    (r_push_evt),
    .i_pop          (evt.evt_ready),
    .i_overflow_clr (overflow_clr),
    .o_head_data    (w_head),
    .o_empty        (w_empty),
    .o_count        (count),
    .o_overflow     (overflow)
  );

  assign evt.evt_valid = !w_empty;
  assign evt.evt_code  = w_head.code;
  assign evt.evt_type  = w_head.evt_type;
  assign held_code     = r_held;

endmodule
`default_nettype wire
